// File: rtl/uart_reg_responder.sv
// uart_reg_responder: byte-protocol register responder on the UART host side.
// Decodes 'W' addr data -> 'K' and 'R' addr -> reg[addr]; anything bad -> '?'.
// Optional build macro UART_REG_CHECKSUM_EN: writes carry a 4th byte,
// csum = 0x57 ^ addr ^ data, and a mismatch is rejected with '?'.
// Ports:
//   clk_50m, rst            clock, async active-high reset
//   rx_data, rx_rdy         received byte and its level-valid flag
//   rx_rdy_clr              one-cycle acknowledge of rx_data
//   tx_din, tx_wr_en        reply byte and one-cycle write strobe
//   tx_busy                 transmitter busy
//   reg_out                 register bank, reg n at [8n+7:8n]
//   cmd_err                 sticky error flag, cleared by reset only
module uart_reg_responder #(
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_rdy_clr,
    output logic [7:0]            tx_din,
    output logic                  tx_wr_en,
    input  logic                  tx_busy,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  cmd_err
);

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] REP_OK  = 8'h4B;
    localparam logic [7:0] REP_ERR = 8'h3F;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef UART_REG_CHECKSUM_EN
        GET_CSUM,
`endif
        EXEC,
        TX_REQ,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    state_t        state;
    logic          cmd_is_wr;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    reply_q;
    logic [TW-1:0] tmo_cnt;
`ifdef UART_REG_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic       rx_state;
    logic       rx_take;
    logic       tmo_hit;
    logic       addr_ok;
    logic       csum_bad;
    logic [7:0] rd_byte;

    always_comb begin
        rx_state = (state == IDLE) || (state == GET_ADDR)
`ifdef UART_REG_CHECKSUM_EN
                || (state == GET_CSUM)
`endif
                || (state == GET_DATA);
        // rdy drops one cycle after clr, so skip the cycle right after a clr
        rx_take = rx_state && rx_rdy && !rx_rdy_clr;
        tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        // full 8-bit compare: no wrap of out-of-range addresses
        addr_ok = int'(addr_q) < NUM_REGS;
`ifdef UART_REG_CHECKSUM_EN
        csum_bad = cmd_is_wr && (csum_q != (CMD_W ^ addr_q ^ data_q));
`else
        csum_bad = 1'b0;
`endif
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) begin
                rd_byte = reg_out[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_is_wr  <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            reply_q    <= 8'h00;
            tmo_cnt    <= '0;
`ifdef UART_REG_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
            rx_rdy_clr <= 1'b0;
            tx_din     <= 8'h00;
            tx_wr_en   <= 1'b0;
            reg_out    <= '0;
            cmd_err    <= 1'b0;
        end else begin
            rx_rdy_clr <= rx_take;
            tx_wr_en   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_take) begin
                        tmo_cnt <= '0;
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            cmd_is_wr <= (rx_data == CMD_W);
                            state     <= GET_ADDR;
                        end else begin
                            reply_q <= REP_ERR;
                            cmd_err <= 1'b1;
                            state   <= TX_REQ;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_take) begin
                        addr_q  <= rx_data;
                        tmo_cnt <= '0;
                        state   <= cmd_is_wr ? GET_DATA : EXEC;
                    end else if (tmo_hit) begin
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GET_DATA: begin
                    if (rx_take) begin
                        data_q  <= rx_data;
                        tmo_cnt <= '0;
`ifdef UART_REG_CHECKSUM_EN
                        state   <= GET_CSUM;
`else
                        state   <= EXEC;
`endif
                    end else if (tmo_hit) begin
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`ifdef UART_REG_CHECKSUM_EN
                GET_CSUM: begin
                    if (rx_take) begin
                        csum_q  <= rx_data;
                        tmo_cnt <= '0;
                        state   <= EXEC;
                    end else if (tmo_hit) begin
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`endif
                EXEC: begin
                    state <= TX_REQ;
                    if (!addr_ok || csum_bad) begin
                        reply_q <= REP_ERR;
                        cmd_err <= 1'b1;
                    end else if (cmd_is_wr) begin
                        reply_q <= REP_OK;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == 8'(i)) begin
                                reg_out[8*i +: 8] <= data_q;
                            end
                        end
                    end else begin
                        reply_q <= rd_byte;
                    end
                end
                TX_REQ: begin
                    if (!tx_busy) begin
                        tx_din   <= reply_q;
                        tx_wr_en <= 1'b1;
                        state    <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= TX_WAIT_LO;
                    end
                end
                TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
Command responder on the host side of the UART byte interface. It consumes bytes delivered by the receiver (data/rdy/rdy_clr) and decodes a byte-oriented read/write register protocol. It drives replies into the transmitter (din/wr_en/tx_busy) and exposes a small bank of 8-bit control registers to the rest of the chip.

Parameters:
NUM_REGS, 4, number of 8-bit registers; valid addresses 0..NUM_REGS-1
TIMEOUT_CYCLES, 5000000, max clk_50m cycles allowed between argument bytes of one command (100 ms at 50 MHz)

Ports:
clk_50m  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte from receiver
rx_rdy  in  1  receiver byte-valid level; held until cleared
rx_rdy_clr  out  1  one-cycle pulse acknowledging rx_data
tx_din  out  8  reply byte to transmitter
tx_wr_en  out  1  one-cycle write strobe to transmitter
tx_busy  in  1  transmitter busy; rises the cycle after an accepted wr_en
reg_out  out  8*NUM_REGS  register bank, reg n at bits [8n+7:8n]
cmd_err  out  1  sticky: any rejected, malformed or timed-out command; cleared by reset only

Behaviour:
- Reset (async, rst=1): state IDLE. reg_out=0, rx_rdy_clr=0, tx_wr_en=0, tx_din=0x00, cmd_err=0, timeout counter=0. Reset mid-command or mid-reply abandons it; no partial register write.
- Byte consume: when rx_rdy=1 in a receive state and rx_rdy_clr was 0 the previous cycle, latch rx_data and pulse rx_rdy_clr for exactly one cycle. The previous-cycle guard prevents double-consuming the same byte, because rdy drops one cycle after clr.
- Protocol:
  - Write: 0x57 ('W'), addr, data -> reply 0x4B ('K').
  - Read: 0x52 ('R'), addr -> reply current reg[addr].
- States: IDLE, GET_ADDR, GET_DATA, [GET_CSUM], EXEC, TX_REQ, TX_WAIT_HI, TX_WAIT_LO.
  - IDLE, byte consumed:
    - 0x57 or 0x52 -> GET_ADDR.
    - Any other byte -> reply 0x3F ('?') and set cmd_err.
  - GET_ADDR:
    - Consumed byte with cmd 'R' -> EXEC.
    - Consumed byte with cmd 'W' -> GET_DATA.
  - GET_DATA: consumed byte -> EXEC (or GET_CSUM when enabled).
  - EXEC, exactly one cycle:
    - addr >= NUM_REGS -> reply '?', set cmd_err, no write.
    - Write: reg[addr] <= data in this cycle; reply 'K'.
    - Read: reply reg[addr] as sampled in EXEC.
  - TX_REQ: wait for tx_busy=0, then drive tx_din and pulse tx_wr_en for one cycle -> TX_WAIT_HI.
  - TX_WAIT_HI: wait for tx_busy=1 -> TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_busy=0 -> IDLE.
  - tx_din holds its value until the next reply.
- Address compare uses the full 8-bit byte, so no wrap-around: addr 0x04 with NUM_REGS=4 is rejected.
- Timeout: counter runs in GET_ADDR, GET_DATA and GET_CSUM. It resets to 0 on each consumed byte and on entry to those states. On reaching TIMEOUT_CYCLES-1, go to IDLE with no reply and set cmd_err. IDLE has no timeout.
- Bytes arriving during EXEC/TX_* are not consumed; they stay pending in the receiver and are processed on return to IDLE. Receiver overrun is not detected here.
- Only one reply is in flight at a time; a new command is never decoded until TX_WAIT_LO completes.

Optional Feature:
UART_REG_CHECKSUM_EN
- Defined: a write command carries a 4th byte, csum = 0x57 ^ addr ^ data, collected in GET_CSUM.
  - Mismatch -> reply '?', set cmd_err, no write.
  - Reads carry no checksum.
- Undefined: GET_CSUM state and checksum logic are absent; a write completes after the data byte.

Test Plan:
- Reset, then bytes 0x57,0x02,0xA5 -> reg_out[23:16]=0xA5 one cycle after EXEC; one tx_wr_en pulse with tx_din=0x4B; other regs stay 0x00.
- After the above, bytes 0x52,0x02 -> single tx_wr_en with tx_din=0xA5; cmd_err=0.
- Byte 0x41 -> reply 0x3F, cmd_err=1. Then 0x57,0x07,0x11 -> reply 0x3F, reg_out unchanged.
- 0x57,0x01, then no byte for TIMEOUT_CYCLES (set to 100 in bench) -> IDLE with no tx_wr_en, cmd_err=1. A following 0x52,0x01 reads back 0x00.
- rx_rdy held high for 3 cycles per byte (slow clear) -> exactly one rx_rdy_clr pulse per byte. Also send a byte while tx_busy=1 -> it is held and consumed only after the reply completes.
- With UART_REG_CHECKSUM_EN: 0x57,0x00,0x3C,0x6B -> write and 'K'; 0x57,0x00,0x3C,0x00 -> '?', reg0 unchanged.
